l1_layer_sched: RTL and testbench

- Sequences one shared `l1_neuron` (N-input signed dot product + bias + ReLU) across M neurons of a layer.
- Holds per-neuron weights and bias in a small register file, written through a config port.
- Accepts one input vector per valid/ready handshake, evaluates neurons 0..M-1 on successive cycles, and presents all M results as one packed output vector with valid/ready.

---
 rtl/l1_pkg.sv | 23 ++
 rtl/l1_neuron.sv | 38 +++
 rtl/l1_layer_sched.sv | 116 +++++++++++
 tb/tb_l1_layer_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l1_pkg
// Purpose  : Shared state encoding and width helpers for the l1 layer blocks.
// Revision : 1.0
// ============================================================================
package l1_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    function automatic int idx_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Two extra bits cover the N-way sum plus the bias add.
    function automatic int yw_of(input int width);
        return 2 * width + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l1_neuron.sv
`default_nettype none
// ============================================================================
// Module   : l1_neuron
// Purpose  : Combinational N-input signed dot product plus bias with ReLU.
// Revision : 1.0
// ============================================================================
module l1_neuron
    import l1_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic [N*WIDTH-1:0]       x,
    input  logic [N*WIDTH-1:0]       w,
    input  logic [WIDTH-1:0]         b,
    output logic [yw_of(WIDTH)-1:0]  y
);

    localparam int YW = yw_of(WIDTH);

    logic signed [2*WIDTH-1:0] w_prod [N];
    logic signed [YW-1:0]      w_acc;

    for (genvar i = 0; i < N; i++) begin : g_prod
        assign w_prod[i] = $signed(x[i*WIDTH +: WIDTH]) * $signed(w[i*WIDTH +: WIDTH]);
    end

    always_comb begin
        w_acc = YW'($signed(b));
        for (int i = 0; i < N; i++) begin
            w_acc = w_acc + YW'(w_prod[i]);
        end
    end

    assign y = w_acc[YW-1] ? '0 : w_acc;

endmodule
`default_nettype wire

// File: rtl/l1_layer_sched.sv
`default_nettype none
// ============================================================================
// Module   : l1_layer_sched
// Purpose  : Time-multiplexes one l1_neuron over M neurons of a layer.
// Revision : 1.0
// ============================================================================
module l1_layer_sched
    import l1_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int M     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [idx_width(M)-1:0]     cfg_addr,
    input  logic [N*WIDTH-1:0]          cfg_w,
    input  logic [WIDTH-1:0]            cfg_b,
    output logic                        cfg_busy,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N*WIDTH-1:0]          in_x,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [M*yw_of(WIDTH)-1:0]   out_y
);

    localparam int IW = idx_width(M);
    localparam int YW = yw_of(WIDTH);
    localparam logic [IW-1:0] c_last_idx = IW'(M - 1);

    logic [1:0]           r_state;
    logic [IW-1:0]        r_idx;
    logic [N*WIDTH-1:0]   r_x;
    logic [N*WIDTH-1:0]   r_w [M];
    logic [WIDTH-1:0]     r_b [M];
    logic [M*YW-1:0]      r_out_y;
    logic                 r_out_valid;

    logic                 w_cfg_ok;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic [YW-1:0]        w_y;

    assign in_ready   = (r_state == c_st_idle) && !rst;
    assign cfg_busy   = (r_state == c_st_run);
    assign out_valid  = r_out_valid;
    assign out_y      = r_out_y;

    // Writes during RUN are discarded so a run always sees one weight snapshot.
    assign w_cfg_ok   = cfg_we && (r_state != c_st_run) && (int'(cfg_addr) < M);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    l1_neuron #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_neuron (
        .x (r_x),
        .w (r_w[r_idx]),
        .b (r_b[r_idx]),
        .y (w_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_idx       <= '0;
            r_x         <= '0;
            r_out_y     <= '0;
            r_out_valid <= 1'b0;
            for (int k = 0; k < M; k++) begin
                r_w[k] <= '0;
                r_b[k] <= '0;
            end
        end else begin
            if (w_cfg_ok) begin
                r_w[cfg_addr] <= cfg_w;
                r_b[cfg_addr] <= cfg_b;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_in_fire) begin
                        r_x     <= in_x;
                        r_idx   <= '0;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_out_y[r_idx*YW +: YW] <= w_y;
                    if (r_idx == c_last_idx) begin
                        r_state     <= c_st_done;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_st_done: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_idx       <= '0;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_idx       <= '0;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l1_layer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_layer_sched
// Purpose  : Scoreboard bench for l1_layer_sched with an abstract layer model.
// Revision : 1.0
// ============================================================================
module tb_l1_layer_sched;
    import l1_pkg::*;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int M     = 4;
    localparam int IW    = idx_width(M);
    localparam int YW    = yw_of(WIDTH);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_we;
    logic [IW-1:0]        cfg_addr;
    logic [N*WIDTH-1:0]   cfg_w;
    logic [WIDTH-1:0]     cfg_b;
    logic                 cfg_busy;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*WIDTH-1:0]   in_x;
    logic                 out_valid;
    logic                 out_ready;
    logic [M*YW-1:0]      out_y;

    always #5 clk = ~clk;

    l1_layer_sched #(.N(N), .WIDTH(WIDTH), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_w     (cfg_w),
        .cfg_b     (cfg_b),
        .cfg_busy  (cfg_busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    // Reference model: weights as integers, layer output computed at acceptance.
    int              mw [M][N];
    int              mb [M];
    logic [M*YW-1:0] exp_q [$];
    logic [M*YW-1:0] last_y = '0;
    bit              inflight = 1'b0;
    int              acc_cyc = 0;
    int              cyc = 0;

    function automatic logic [M*YW-1:0] predict(input logic [N*WIDTH-1:0] x);
        logic [M*YW-1:0] r;
        int s;
        r = '0;
        for (int k = 0; k < M; k++) begin
            s = mb[k];
            for (int i = 0; i < N; i++) s += mw[k][i] * int'($signed(x[i*WIDTH +: WIDTH]));
            if (s < 0) s = 0;
            r[k*YW +: YW] = YW'(s);
        end
        return r;
    endfunction

    function automatic logic [N*WIDTH-1:0] pk(input int e3, input int e2, input int e1, input int e0);
        return {WIDTH'(e3), WIDTH'(e2), WIDTH'(e1), WIDTH'(e0)};
    endfunction

    initial begin : model
        bit e_busy, e_valid, e_ready;
        for (int k = 0; k < M; k++) begin
            mb[k] = 0;
            for (int i = 0; i < N; i++) mw[k][i] = 0;
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_busy  = inflight && (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + M);
            e_valid = inflight && (cyc > acc_cyc + M);
            e_ready = !inflight && !rst;
            chk("in_ready", in_ready, e_ready);
            chk("cfg_busy", cfg_busy, e_busy);
            chk("out_valid", out_valid, e_valid);
            if (e_valid) begin
                if (exp_q.size() == 0) tmo("scoreboard_empty");
                else chk("out_y", out_y, exp_q[0]);
            end else if (!e_busy) begin
                chk("out_y_hold", out_y, last_y);
            end
            if (rst) begin
                for (int k = 0; k < M; k++) begin
                    mb[k] = 0;
                    for (int i = 0; i < N; i++) mw[k][i] = 0;
                end
                exp_q.delete();
                inflight = 1'b0;
                last_y   = '0;
            end else begin
                if (cfg_we && !e_busy && int'(cfg_addr) < M) begin
                    for (int i = 0; i < N; i++) mw[cfg_addr][i] = $signed(cfg_w[i*WIDTH +: WIDTH]);
                    mb[cfg_addr] = $signed(cfg_b);
                end
                if (in_valid && e_ready) begin
                    exp_q.push_back(predict(in_x));
                    inflight = 1'b1;
                    acc_cyc  = cyc;
                end else if (e_valid && out_ready) begin
                    last_y   = exp_q.pop_front();
                    inflight = 1'b0;
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int a, input logic [N*WIDTH-1:0] wv, input int bv);
        cfg_we   = 1'b1;
        cfg_addr = IW'(a);
        cfg_w    = wv;
        cfg_b    = WIDTH'(bv);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) tmo("wait_in_ready");
    endtask

    task automatic send(input logic [N*WIDTH-1:0] xv);
        wait_ready();
        in_valid = 1'b1;
        in_x     = xv;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 1;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        if (!out_valid) tmo("wait_out_valid");
    endtask

    initial begin : stim
        logic [N*WIDTH-1:0] xv;
        logic [M*YW-1:0]    ev;
        int                 k;
        int                 hs [$];

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_w = '0; cfg_b = '0;
        in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1'b1);
        chk("idle_out_y", out_y, '0);
        chk("idle_cfg_busy", cfg_busy, 1'b0);
        tick();

        // Basic layer with backpressure
        xv = pk(4, 3, 2, 1);
        cfg(0, pk(1, 1, 1, 1), 5);
        cfg(1, pk(-1, -1, -1, -1), -1);
        cfg(2, pk(2, 3, 4, 5), 3);
        cfg(3, '0, 0);
        ev = '0;
        ev[0*YW +: YW] = YW'(15);
        ev[2*YW +: YW] = YW'(33);
        out_ready = 1'b0;
        send(xv);
        wait_valid(k);
        chk("latency", k, 5);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_y", out_y, ev);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        chk("release_in_ready", in_ready, 1'b1);
        chk("release_out_valid", out_valid, 1'b0);

        // Config write dropped during RUN
        send(xv);
        chk("run_cfg_busy", cfg_busy, 1'b1);
        tick();
        cfg(0, pk(1, 1, 1, 1), 100);
        wait_valid(k);
        chk("run_write_slot0", out_y[0 +: YW], 15);
        send(xv);
        wait_valid(k);
        chk("rerun_slot0", out_y[0 +: YW], 15);

        // Same-edge config and input
        wait_ready();
        cfg_we = 1'b1; cfg_addr = '0; cfg_w = '0; cfg_b = WIDTH'(7);
        in_valid = 1'b1; in_x = xv;
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        wait_valid(k);
        chk("same_edge_slot0", out_y[0 +: YW], 7);

        // Back-to-back acceptance period
        in_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            in_x = $urandom;
            if (in_ready) hs.push_back(c);
            tick();
        end
        in_valid = 1'b0;
        if (hs.size() >= 3) begin
            chk("b2b_period0", hs[1] - hs[0], 6);
            chk("b2b_period1", hs[2] - hs[1], 6);
        end else begin
            tmo("b2b_accepts");
        end

        // Reset at RUN idx 2
        send(xv);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_y", out_y, '0);
        chk("midrst_in_ready", in_ready, 1'b1);
        send(xv);
        wait_valid(k);
        chk("midrst_rerun", out_y, '0);
        tick();

        // Randomized traffic against the model
        for (int a = 0; a < M; a++) cfg(a, $urandom, int'($urandom_range(0, 255)));
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 249) == 0);
            cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_addr  = IW'($urandom);
            cfg_w     = $urandom;
            cfg_b     = WIDTH'($urandom);
            in_valid  = ($urandom_range(0, 1) == 1);
            in_x      = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
